// File: rtl/sroute_pkg.sv
// Shared types and widths for the source-routed switch ingress path.
package sroute_pkg;

  localparam int PORT_W = 5;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    DISCARD
  } in_state_t;

  typedef enum logic {
    OIDLE,
    SEND
  } out_state_t;

  // One buffered payload byte with its packet boundary flags.
  typedef struct packed {
    logic              first;
    logic              last;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/ingress_port_if.sv
// Link-side input and arbiter-side output handshake of one ingress port.
interface ingress_port_if;
  import sroute_pkg::*;

  // upstream link
  logic              pushin;
  logic              firstin;
  logic              lastin;
  logic [BYTE_W-1:0] datain;
  logic              stopout;

  // arbiter / memory controller
  logic              req;
  logic [PORT_W-1:0] dest;
  logic              grant;
  logic              stop;
  logic              pushout;
  logic              firstout;
  logic              lastout;
  logic [BYTE_W-1:0] dataout;

  // Port side: receives bytes, presents committed packets.
  modport slave (
    input  pushin, firstin, lastin, datain, grant, stop,
    output stopout, req, dest, pushout, firstout, lastout, dataout
  );

  // Environment side: the link and the arbiter.
  modport master (
    output pushin, firstin, lastin, datain, grant, stop,
    input  stopout, req, dest, pushout, firstout, lastout, dataout
  );

endinterface

// File: rtl/ingress_port_pkt_fifo.sv
// Circular buffer with a tentative write pointer: writes become visible to
// the reader only after commit, and rollback discards uncommitted writes.
module pkt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   used
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, wr_commit, rd_ptr;
  logic [AW:0]  wr_ptr_inc;

  assign wr_ptr_inc = wr_ptr + ONE;

  // Storage write; a rollback in the same cycle cancels the write.
  // NOTE: the storage array is deliberately not reset -- pointers define
  // validity, and resetting a RAM would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en && !rollback) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer registers; rollback returns the writer to the last commit point.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
    end else begin
      if (rollback)   wr_ptr <= wr_commit;
      else if (wr_en) wr_ptr <= wr_ptr_inc;
      if (commit && !rollback) wr_commit <= wr_en ? wr_ptr_inc : wr_ptr;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign used    = wr_ptr - rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // The reader only ever sees committed data.
  assign empty   = (wr_commit == rd_ptr);

endmodule

// File: rtl/ingress_port.sv
// Ingress stage: strips the route byte, buffers the payload store-and-forward,
// drops malformed/overflowing packets and streams committed packets out.
module ingress_port
  import sroute_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int HDEPTH  = 8,
  parameter int STOP_TH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enabled,
  ingress_port_if.slave       bus,
  output logic [7:0]          drop_count
);

  localparam int PAW = $clog2(DEPTH);
  localparam int HAW = $clog2(HDEPTH);
  localparam logic [PAW:0] STOP_LVL = (PAW+1)'(DEPTH - STOP_TH);

  in_state_t         in_state, in_nxt;
  out_state_t        out_state, out_nxt;
  logic [PORT_W-1:0] dest_in, hd_head;
  logic              first_pend;
  logic              accept;
  logic              pay_wr, pay_commit, pay_rollback, pay_rd, pay_full, pay_empty;
  logic [PAW:0]      pay_used;
  entry_t            wr_entry, pay_head;
  logic              hd_wr, hd_pop, hd_full, hd_empty;
  logic [HAW:0]      pkt_count;
  logic              drop_inc, latch_dest;
  logic              req_int, grant_ok, send, last_sent;
  logic              out_push, out_first, out_last, stop_r;
  logic [BYTE_W-1:0] out_data;

  assign accept   = bus.pushin && enabled;
  assign wr_entry = '{first: first_pend, last: bus.lastin, data: bus.datain};

  pkt_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_payload (
    .clk, .reset,
    .wr_en(pay_wr), .wr_data(wr_entry), .commit(pay_commit), .rollback(pay_rollback),
    .rd_en(pay_rd), .rd_data(pay_head), .full(pay_full), .empty(pay_empty), .used(pay_used)
  );

  // Destination queue: every write is a whole packet, so commit follows write
  // and its occupancy is the committed packet count.
  pkt_fifo #(.W(PORT_W), .DEPTH(HDEPTH)) u_dest (
    .clk, .reset,
    .wr_en(hd_wr), .wr_data(dest_in), .commit(hd_wr), .rollback(1'b0),
    .rd_en(hd_pop), .rd_data(hd_head), .full(hd_full), .empty(hd_empty), .used(pkt_count)
  );

  // Input FSM decode: parse route byte, buffer payload, commit or roll back.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    in_nxt       = in_state;
    pay_wr       = 1'b0;
    pay_commit   = 1'b0;
    pay_rollback = 1'b0;
    hd_wr        = 1'b0;
    drop_inc     = 1'b0;
    latch_dest   = 1'b0;
    case (in_state)
      IDLE, DISCARD: begin
        if (accept) begin
          if (bus.firstin) begin
            if (bus.lastin) begin
              drop_inc = 1'b1;              // route byte with no payload
              in_nxt   = IDLE;
            end else begin
              latch_dest = 1'b1;
              in_nxt     = BODY;
            end
          end else if (in_state == IDLE) begin
            drop_inc = 1'b1;                // stray byte outside a packet
          end else if (bus.lastin) begin
            in_nxt = IDLE;                  // end of the discarded packet
          end
        end
      end
      BODY: begin
        if (!enabled) begin
          pay_rollback = 1'b1;
          drop_inc     = 1'b1;
          in_nxt       = IDLE;
        end else if (bus.pushin) begin
          if (bus.firstin) begin
            // Truncated packet: the new byte is the next packet's route byte.
            pay_rollback = 1'b1;
            drop_inc     = 1'b1;
            if (bus.lastin) in_nxt = IDLE;
            else            latch_dest = 1'b1;
          end else if (pay_full || (bus.lastin && hd_full)) begin
            pay_rollback = 1'b1;
            drop_inc     = 1'b1;
            in_nxt       = bus.lastin ? IDLE : DISCARD;
          end else begin
            pay_wr = 1'b1;
            if (bus.lastin) begin
              pay_commit = 1'b1;
              hd_wr      = 1'b1;
              in_nxt     = IDLE;
            end
          end
        end
      end
      default: in_nxt = IDLE;
    endcase
  end

  // Input FSM state, route latch, drop counter and registered backpressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_state   <= IDLE;
      dest_in    <= '0;
      first_pend <= 1'b0;
      drop_count <= '0;
      stop_r     <= 1'b0;
    end else begin
      in_state <= in_nxt;
      if (latch_dest) begin
        dest_in    <= bus.datain[PORT_W-1:0];
        first_pend <= 1'b1;
      end else if (pay_wr) begin
        first_pend <= 1'b0;
      end
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      stop_r <= (pay_used >= STOP_LVL);
    end
  end

  // Output FSM decode. req is held low in the cycle that shows lastout so a
  // following packet is requested one cycle later.
  always_comb begin
    req_int   = (out_state == OIDLE) && (pkt_count != '0) && !(out_push && out_last);
    grant_ok  = req_int && bus.grant;
    send      = !bus.stop && !pay_empty && (grant_ok || out_state == SEND);
    last_sent = send && pay_head.last;
    pay_rd    = send;
    hd_pop    = last_sent && !hd_empty;
    out_nxt   = out_state;
    case (out_state)
      OIDLE:   if (grant_ok) out_nxt = last_sent ? OIDLE : SEND;
      SEND:    if (last_sent) out_nxt = OIDLE;
      default: out_nxt = OIDLE;
    endcase
  end

  // Output FSM state and registered output byte; a stall holds the data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_state <= OIDLE;
      out_push  <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_state <= out_nxt;
      out_push  <= send;
      if (send) begin
        out_first <= pay_head.first;
        out_last  <= pay_head.last;
        out_data  <= pay_head.data;
      end
    end
  end

  assign bus.stopout  = stop_r;
  assign bus.req      = req_int;
  assign bus.dest     = req_int ? hd_head : '0;
  assign bus.pushout  = out_push;
  assign bus.firstout = out_first;
  assign bus.lastout  = out_last;
  assign bus.dataout  = out_data;

endmodule

// File: tb/tb_ingress_port.sv
// Directed bench for ingress_port with a queue-based scoreboard.
module tb_ingress_port;
  import sroute_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enabled;
  logic [7:0] drop_count;

  ingress_port_if bus();

  ingress_port #(.DEPTH(64), .HDEPTH(8), .STOP_TH(4)) dut (
    .clk(clk), .reset(reset), .enabled(enabled), .bus(bus), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  entry_t     exp_q[$];
  logic [4:0] dest_q[$];
  logic       auto_grant = 1'b0;
  logic       stop_seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic l, input logic [7:0] d);
    bus.pushin  = 1'b1;
    bus.firstin = f;
    bus.lastin  = l;
    bus.datain  = d;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.pushin  = 1'b0;
    bus.firstin = 1'b0;
    bus.lastin  = 1'b0;
    bus.datain  = 8'h00;
  endtask

  task automatic expect_beat(input logic f, input logic l, input logic [7:0] d);
    exp_q.push_back('{first: f, last: l, data: d});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || dest_q.size() != 0); i++) @(negedge clk);
    check("drain", 32'(exp_q.size() + dest_q.size()), 32'd0);
  endtask

  task automatic wait_out(input logic want_last);
    logic found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.pushout && (want_last ? bus.lastout : bus.firstout)) found = 1'b1;
    end
    check(want_last ? "saw_lastout" : "saw_firstout", 32'(found), 32'd1);
  endtask

  // Arbiter model: grants whenever enabled and the port requests.
  initial begin
    bus.grant = 1'b0;
    forever begin
      @(negedge clk);
      bus.grant = auto_grant & bus.req;
    end
  end

  // Monitor: compares every output beat and granted destination in order.
  initial begin
    entry_t e;
    logic   gnt_q = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (bus.stopout) stop_seen = 1'b1;
      if (gnt_q) check("req_drop_after_grant", 32'(bus.req), 32'd0);
      gnt_q = bus.req && bus.grant;
      if (bus.req && bus.grant) begin
        check("dest_avail", 32'(dest_q.size() != 0), 32'd1);
        if (dest_q.size() != 0) check("dest", 32'(bus.dest), 32'(dest_q.pop_front()));
      end
      if (bus.pushout) begin
        check("beat_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", 32'({bus.firstout, bus.lastout, bus.dataout}), 32'(e));
        end
        if (bus.lastout) check("req_low_at_last", 32'(bus.req), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    enabled  = 1'b1;
    bus.stop = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_pushout", 32'(bus.pushout), 32'd0);
    check("rst_stopout", 32'(bus.stopout), 32'd0);
    check("rst_dest", 32'(bus.dest), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);

    // Basic packet to port 19.
    auto_grant = 1'b1;
    dest_q.push_back(5'd19);
    expect_beat(1, 0, 8'hAA); expect_beat(0, 0, 8'hBB); expect_beat(0, 1, 8'hCC);
    drive(1, 0, 8'h13); drive(0, 0, 8'hAA); drive(0, 0, 8'hBB); drive(0, 1, 8'hCC); idle();
    wait_drain();
    check("t1_drop", 32'(drop_count), 32'd0);

    // Same packet with a two-cycle downstream stall after the first byte.
    dest_q.push_back(5'd19);
    expect_beat(1, 0, 8'hAA); expect_beat(0, 0, 8'hBB); expect_beat(0, 1, 8'hCC);
    drive(1, 0, 8'h13); drive(0, 0, 8'hAA); drive(0, 0, 8'hBB); drive(0, 1, 8'hCC); idle();
    wait_out(1'b0);
    bus.stop = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      check("stall_pushout", 32'(bus.pushout), 32'd0);
    end
    bus.stop = 1'b0;
    wait_drain();

    // Truncated packet rolled back by a new route byte.
    dest_q.push_back(5'd7);
    expect_beat(1, 0, 8'h33); expect_beat(0, 1, 8'h44);
    drive(1, 0, 8'h05); drive(0, 0, 8'h11); drive(0, 0, 8'h22);
    drive(1, 0, 8'h07); drive(0, 0, 8'h33); drive(0, 1, 8'h44); idle();
    wait_drain();
    check("t3_drop", 32'(drop_count), 32'd1);

    // Overflow: 69 payload bytes into a 64-entry buffer with no grant.
    auto_grant = 1'b0;
    stop_seen  = 1'b0;
    drive(1, 0, 8'h0A);
    for (int i = 1; i <= 69; i++) drive(1'b0, i == 69, 8'(i));
    idle();
    repeat (3) @(negedge clk);
    #1;
    check("ovf_stop_seen", 32'(stop_seen), 32'd1);
    check("ovf_stop_clear", 32'(bus.stopout), 32'd0);
    check("ovf_no_req", 32'(bus.req), 32'd0);
    check("ovf_drop", 32'(drop_count), 32'd2);
    auto_grant = 1'b1;
    dest_q.push_back(5'd12);
    expect_beat(1, 0, 8'h5A); expect_beat(0, 1, 8'h5B);
    drive(1, 0, 8'h0C); drive(0, 0, 8'h5A); drive(0, 1, 8'h5B); idle();
    wait_drain();

    // Two committed packets, then granted back to back.
    auto_grant = 1'b0;
    dest_q.push_back(5'd3);
    expect_beat(1, 0, 8'h31); expect_beat(0, 1, 8'h32);
    dest_q.push_back(5'd9);
    expect_beat(1, 0, 8'h91); expect_beat(0, 1, 8'h92);
    drive(1, 0, 8'h03); drive(0, 0, 8'h31); drive(0, 1, 8'h32);
    drive(1, 0, 8'h09); drive(0, 0, 8'h91); drive(0, 1, 8'h92); idle();
    @(negedge clk);
    auto_grant = 1'b1;
    wait_out(1'b1);
    @(negedge clk); #1;
    check("b2b_req_after_bubble", 32'(bus.req), 32'd1);
    check("b2b_dest", 32'(bus.dest), 32'd9);
    wait_drain();
    check("b2b_drop", 32'(drop_count), 32'd2);

    // Reset for one cycle in the middle of a transfer.
    dest_q.push_back(5'd21);
    for (int i = 1; i <= 6; i++) expect_beat(i == 1, i == 6, 8'(i));
    drive(1, 0, 8'h15);
    for (int i = 1; i <= 6; i++) drive(1'b0, i == 6, 8'(i));
    idle();
    wait_out(1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    dest_q.delete();
    #1;
    check("mid_rst_pushout", 32'(bus.pushout), 32'd0);
    check("mid_rst_req", 32'(bus.req), 32'd0);
    check("mid_rst_data", 32'({bus.firstout, bus.lastout, bus.dataout}), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("mid_rst_empty", 32'(bus.req), 32'd0);
    dest_q.push_back(5'd2);
    expect_beat(1, 1, 8'h77);
    @(negedge clk);
    drive(1, 0, 8'h02); drive(0, 1, 8'h77); idle();
    wait_drain();

    // Port disabled mid-packet: packet dropped, nothing presented.
    drive(1, 0, 8'h04); drive(0, 0, 8'h55); idle();
    enabled = 1'b0;
    @(negedge clk);
    enabled = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("dis_drop", 32'(drop_count), 32'd1);
    check("dis_no_req", 32'(bus.req), 32'd0);

    // Drop counter saturation.
    @(negedge clk);
    for (int i = 0; i < 260; i++) drive(1, 1, 8'h01);
    idle();
    @(negedge clk); #1;
    check("drop_saturate", 32'(drop_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ingress_port.md
Name: ingress_port

Overview:
- Per-port ingress stage of the source-routed switch; one instance per port, 32 in the switch top.
- Strips the leading route byte from each incoming packet and buffers the payload store-and-forward.
- Discards truncated or overflowing packets.
- Presents committed packets, with their 5-bit destination, to the arbiter / memory controller as a request/grant/stop streaming handshake.

Parameters:
- DEPTH, 64: payload FIFO entries; power of two.
- HDEPTH, 8: destination FIFO entries (committed packets); power of two.
- STOP_TH, 4: stopout asserted when free payload entries <= STOP_TH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- enabled  in  1  port enable; input ignored while low
- pushin  in  1  input byte valid
- firstin  in  1  first byte of packet (the route byte)
- lastin  in  1  last byte of packet
- datain  in  8  input byte
- stopout  out  1  backpressure to upstream link
- req  out  1  committed packet available
- dest  out  5  destination port of the head packet; valid while req
- grant  in  1  arbiter grant; accepted only when req=1
- stop  in  1  downstream stall (memory write_stop)
- pushout  out  1  output byte valid
- firstout  out  1  first payload byte
- lastout  out  1  last payload byte
- dataout  out  8  output byte
- drop_count  out  8  dropped/violating packet count, saturating at 255

Behaviour:
- Reset (reset=0 at clk edge):
  - All outputs 0; all pointers and counters 0.
  - Input FSM to IDLE, output FSM to OIDLE.
  - Reset mid-packet discards all buffered data.
- Input FSM, states IDLE / BODY / DISCARD. A byte is accepted only when pushin & enabled.
  - IDLE, byte with firstin & !lastin: latch dest_in = datain[4:0]; go to BODY. The route byte is not stored.
  - IDLE, byte with firstin & lastin (no payload): drop_count++; stay in IDLE.
  - IDLE, byte without firstin: ignored; drop_count++.
  - BODY, byte: write {first, last, data} at wr_ptr; wr_ptr++. The first flag is set on the first payload byte only.
  - BODY, lastin: commit (wr_commit = new wr_ptr; push dest_in to dest FIFO); go to IDLE.
  - BODY, firstin: rollback (wr_ptr = wr_commit); drop_count++; treat this byte as a new route byte and stay in BODY.
  - BODY, payload FIFO full at write, or dest FIFO full at commit: rollback; drop_count++; go to DISCARD, or to IDLE if the byte carried lastin.
  - DISCARD: consume bytes until lastin, then go to IDLE. firstin in DISCARD restarts as in IDLE.
  - enabled falling while in BODY: rollback; drop_count++; go to IDLE.
- stopout is registered: stopout = (DEPTH - (wr_ptr - rd_ptr)) <= STOP_TH, computed with mod-DEPTH pointer arithmetic plus a wrap bit.
- Output FSM, states OIDLE / SEND. The reader sees only committed entries (rd_ptr never passes wr_commit), so rollback never affects it.
  - OIDLE: req = (pkt_count > 0); dest = head of dest FIFO.
  - grant & req: req drops next cycle; go to SEND.
  - SEND, stop=0: one entry per cycle. pushout, firstout, lastout, dataout are registered from the FIFO head, so the first pushout appears 1 cycle after grant.
  - SEND, stop=1: pushout=0; no pointer advance; data held.
  - After the entry carrying lastout is sent: pop dest FIFO; pkt_count--; go to OIDLE. req can reassert the cycle after lastout (one bubble).
  - grant while req=0: ignored.
- pkt_count: commit and pop in the same cycle leaves it unchanged.
- drop_count saturates at 255.

Decomposition:
- Shared package sroute_pkg:
  - PORT_W=5, BYTE_W=8.
  - Input state enum {IDLE, BODY, DISCARD}.
  - Output state enum {OIDLE, SEND}.
  - FIFO entry struct {first, last, data[7:0]}.
- One sub-module: pkt_fifo, a parameterised circular buffer with wr_ptr / wr_commit / rd_ptr, commit and rollback strobes, and wrap-bit full/empty. Instantiated once for payload. The dest FIFO is a plain instance of the same module with commit tied to write.

Test Plan:
- Packet 0x13,AA,BB,CC (firstin on 0x13, lastin on CC), grant at first req -> req=1, dest=19; after grant, pushout for 3 cycles with AA(firstout), BB, CC(lastout); drop_count=0.
- Same packet with stop=1 for 2 cycles mid-transfer -> pushout=0 during the stall, BB held, no byte lost or duplicated, CC last.
- Packet 0x05,11,22, then firstin 0x07,33,44(lastin) -> first packet rolled back; only dest=7 / 33,44 emerges; drop_count=1.
- DEPTH=64, no grant, 70-byte packet -> stopout rises when free<=4; packet dropped, rd side empty, drop_count=1; a following 2-byte packet is delivered.
- Two packets committed back-to-back (dests 3 then 9), grant each -> dest order 3, 9; one idle cycle between lastout and the second req.
- reset=0 for one cycle during SEND -> all outputs 0 next cycle, req=0, drop_count=0, FIFO empty.
